// File: rtl/pe_arr_drain.sv
// Result drain behind the systolic PE array: snapshots the full
// accumulator bus on start, then streams it row-major over valid/ready.
//
// Ports:
//   clk, rstn     clock, async active-low reset
//   start         snapshot request (IDLE only)
//   outs_port     rows*cols 32-bit results, element k at [32k:32k+31]
//   busy          high while streaming or in the done cycle
//   out_valid/out_ready/out_data/out_idx/out_last  result stream
//   done          one-cycle pulse after the final transfer
module pe_arr_drain #(
  parameter  int rows = 16,
  parameter  int cols = 16,
  localparam int N    = rows * cols,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [0:32*N-1] outs_port,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   buf_q [N];
  logic          cap;

  assign cap = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot decouples the array from the drain once start is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++)
        buf_q[k] <= '0;
    end else if (cap) begin
      for (int k = 0; k < N; k++)
        buf_q[k] <= outs_port[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic stream;
  assign stream    = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = stream;
  assign out_data  = stream ? buf_q[idx_q] : '0;
  assign out_idx   = idx_q;
  assign out_last  = stream && (idx_q == LAST);

endmodule

// File: tb/tb_pe_arr_drain.sv
// Bench for pe_arr_drain on a 2x2 array: directed scenarios
// plus random start/ready traffic against a word-queue model.
module tb_pe_arr_drain;

  localparam int R = 2;
  localparam int C = 2;
  localparam int N = R * C;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [0:32*N-1] outs;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            done;

  pe_arr_drain #(.rows(R), .cols(C)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .outs_port (outs),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          idx;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pw[N];
  int          m_left = 0;
  bit          m_done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void set_words(input logic [31:0] base,
                                    input logic [31:0] step);
    for (int k = 0; k < N; k++) begin
      pw[k] = base + step * k;
      outs[32*k +: 32] = pw[k];
    end
  endfunction

  function automatic void rnd_words();
    for (int k = 0; k < N; k++) begin
      pw[k] = $urandom;
      outs[32*k +: 32] = pw[k];
    end
  endfunction

  // Reference: an accepted start queues all N words; the stream
  // lasts until N ready cycles have passed, then one done cycle.
  function automatic void edge_model();
    exp_t e;
    if (!rstn) return;
    if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      if (out_ready) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (start) begin
      for (int k = 0; k < N; k++) begin
        e.d    = pw[k];
        e.idx  = k;
        e.last = (k == N - 1);
        q.push_back(e);
      end
      m_left = N;
    end
  endfunction

  task automatic cyc(input logic st, input logic rdy);
    start     = st;
    out_ready = rdy;
    @(posedge clk);
    edge_model();
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, 32'(out_idx), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Monitor: compares handshake-level outputs every cycle and pops
  // the scoreboard on each transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
      end else begin
        chk("busy", 32'(busy), 32'(m_left > 0 || m_done));
        chk("valid", 32'(out_valid), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_done));
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word got %h want none", out_data);
          end else begin
            e = q[0];
            chk("data", out_data, e.d);
            chk("idx", 32'(out_idx), 32'(e.idx));
            chk("last", 32'(out_last), 32'(e.last));
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rstn      = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    set_words(32'h1000_0000, 1);
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) cyc(0, 0);
    rstn = 1'b1;
    cyc(0, 1);

    // basic drain
    cyc(1, 1);
    repeat (6) cyc(0, 1);

    // backpressure at idx 1
    cyc(1, 1);
    cyc(0, 1);
    repeat (3) cyc(0, 0);
    repeat (6) cyc(0, 1);

    // snapshot isolation
    cyc(1, 1);
    set_words(32'hFFFF_FFFF, 0);
    repeat (6) cyc(0, 1);
    set_words(32'h1000_0000, 1);

    // start while busy, then start in first IDLE cycle
    cyc(1, 1);
    cyc(0, 1);
    cyc(0, 1);
    cyc(1, 1);
    cyc(0, 1);
    set_words(32'h2000_0000, 1);
    cyc(1, 1);
    cyc(1, 1);
    repeat (6) cyc(0, 1);

    // reset mid-stream at idx 1
    set_words(32'h1000_0000, 1);
    cyc(1, 1);
    cyc(0, 1);
    #2;
    rstn = 1'b0;
    q.delete();
    m_left = 0;
    m_done = 0;
    #1;
    chk_zero("midrst");
    cyc(0, 1);
    cyc(0, 1);
    rstn = 1'b1;
    repeat (3) cyc(0, 1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL midrst_queue got %0d want 0", q.size());
    end
    cyc(1, 1);
    repeat (6) cyc(0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) rnd_words();
      cyc(logic'($urandom_range(3) == 0),
          logic'($urandom_range(2) != 0));
    end
    start = 1'b0;
    repeat (12) cyc(0, 1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_left got %0d want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
